// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, response and arithmetic-unit signals of the ALU arbiter.
// slave is the arbiter's view; master is the requester/unit environment's view.
interface alu_arbiter_if;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [3:0]   req_op;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [63:0]  rsp_lo;
  logic [63:0]  rsp_hi;
  logic         rsp_err;
  logic         alu_bgn;
  logic [1:0]   alu_opcode;
  logic [63:0]  alu_inbus;
  logic         alu_stop;
  logic [63:0]  alu_outbus;
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_stop, alu_outbus,
    output req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_err, alu_bgn, alu_opcode, alu_inbus
  );
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_stop, alu_outbus,
    input  req_ready, rsp_valid, rsp_lo, rsp_hi, rsp_err, alu_bgn, alu_opcode, alu_inbus
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one multi-cycle arithmetic unit between two requesters.
// One operation in flight; all outputs are registered.
module alu_arbiter #(
  parameter int TIMEOUT = 300
) (
  input logic         clk,
  input logic         rst_b,
  alu_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, START, LOAD_A, LOAD_B, WAIT, CAP_LO, CAP_HI, RESP} state_t;
  state_t        r_state;
  logic          r_id;
  logic          r_last;
  logic [1:0]    r_op;
  logic [63:0]   r_a;
  logic [63:0]   r_b;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_req_ready;
  logic [1:0]    r_rsp_valid;
  logic [63:0]   r_rsp_lo;
  logic [63:0]   r_rsp_hi;
  logic          r_rsp_err;
  logic          r_alu_bgn;
  logic [1:0]    r_alu_opcode;
  logic [63:0]   r_alu_inbus;
  logic          w_win;
  logic [1:0]    w_win_oh;
  logic [1:0]    w_id_oh;
  logic [1:0]    w_op;
  logic [63:0]   w_a;
  logic [63:0]   w_b;
  logic          w_dz;
  // On a tie the requester that was not granted last wins.
  always_comb begin
    w_win    = &bus.req_valid ? ~r_last : bus.req_valid[1];
    w_win_oh = w_win ? 2'b10 : 2'b01;
    w_id_oh  = r_id ? 2'b10 : 2'b01;
    w_op     = w_win ? bus.req_op[3:2] : bus.req_op[1:0];
    w_a      = w_win ? bus.req_a[127:64] : bus.req_a[63:0];
    w_b      = w_win ? bus.req_b[127:64] : bus.req_b[63:0];
    w_dz     = (w_op == 2'b11) && (w_b == 64'd0);
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state      <= IDLE;
      r_id         <= 1'b0;
      r_last       <= 1'b1;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_cnt        <= '0;
      r_req_ready  <= '0;
      r_rsp_valid  <= '0;
      r_rsp_lo     <= '0;
      r_rsp_hi     <= '0;
      r_rsp_err    <= 1'b0;
      r_alu_bgn    <= 1'b0;
      r_alu_opcode <= '0;
      r_alu_inbus  <= '0;
    end else begin
      r_req_ready <= '0;
      r_alu_bgn   <= 1'b0;
      case (r_state)
        IDLE: if (|bus.req_valid) begin
          r_id        <= w_win;
          r_last      <= w_win;
          r_op        <= w_op;
          r_a         <= w_a;
          r_b         <= w_b;
          r_req_ready <= w_win_oh;
          r_rsp_lo    <= '0;
          r_rsp_hi    <= '0;
          r_rsp_err   <= w_dz;
          // Division by zero never reaches the unit.
          if (w_dz) begin
            r_state     <= RESP;
            r_rsp_valid <= w_win_oh;
          end else begin
            r_state      <= START;
            r_alu_bgn    <= 1'b1;
            r_alu_opcode <= w_op;
          end
        end
        START: begin
          r_state     <= LOAD_A;
          r_alu_inbus <= r_a;
        end
        LOAD_A: begin
          r_state     <= LOAD_B;
          r_alu_inbus <= r_b;
        end
        LOAD_B: begin
          r_state     <= WAIT;
          r_alu_inbus <= '0;
          r_cnt       <= '0;
        end
        WAIT: if (bus.alu_stop) begin
          r_state <= CAP_LO;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          r_state      <= RESP;
          r_rsp_err    <= 1'b1;
          r_rsp_valid  <= w_id_oh;
          r_alu_opcode <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        CAP_LO: begin
          r_rsp_lo <= bus.alu_outbus;
          if (!r_op[1]) begin
            r_state      <= RESP;
            r_rsp_valid  <= w_id_oh;
            r_alu_opcode <= '0;
          end else begin
            r_state <= CAP_HI;
          end
        end
        CAP_HI: begin
          r_rsp_hi     <= bus.alu_outbus;
          r_state      <= RESP;
          r_rsp_valid  <= w_id_oh;
          r_alu_opcode <= '0;
        end
        RESP: if (|(bus.rsp_ready & r_rsp_valid)) begin
          r_rsp_valid <= '0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.req_ready  = r_req_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_lo     = r_rsp_lo;
  assign bus.rsp_hi     = r_rsp_hi;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.alu_bgn    = r_alu_bgn;
  assign bus.alu_opcode = r_alu_opcode;
  assign bus.alu_inbus  = r_alu_inbus;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors against alu_arbiter with a behavioural arithmetic unit.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  alu_arbiter_if bus();
  alu_arbiter #(.TIMEOUT(300)) dut (.clk(clk), .rst_b(rst_b), .bus(bus.slave));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_err = 0;
  bit hang = 1'b0;
  bit stop_inj = 1'b0;
  int m_st = 0;
  int m_n = 0;
  int m_bgn = 0;
  int m_bad = 0;
  logic [1:0]   m_op;
  logic [63:0]  m_a;
  logic [63:0]  m_b;
  logic [127:0] m_res;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  // Unit model: lo appears the cycle after stop, hi the cycle after that.
  initial begin
    bus.alu_stop = 1'b0;
    bus.alu_outbus = '0;
    forever begin
      @(negedge clk);
      bus.alu_stop = stop_inj;
      if (bus.alu_bgn) begin
        m_op = bus.alu_opcode;
        m_st = 1;
        m_bgn++;
      end else if (m_st == 1 || m_st == 2) begin
        if (bus.alu_bgn !== 1'b0 || bus.alu_opcode !== m_op) m_bad++;
        if (m_st == 1) m_a = bus.alu_inbus;
        else m_b = bus.alu_inbus;
        if (m_st == 2) begin
          m_res = m_op == 2'd0 ? {64'd0, m_a + m_b} :
                  m_op == 2'd1 ? {64'd0, m_a - m_b} :
                  m_op == 2'd2 ? {64'd0, m_a} * {64'd0, m_b} : {m_a % m_b, m_a / m_b};
          m_n = 0;
        end
        m_st = m_st + 1;
      end else if (m_st == 3) begin
        if (m_n < 3 && (bus.alu_inbus !== 64'd0 || bus.alu_opcode !== m_op)) m_bad++;
        if (!hang && m_n == 2) begin
          bus.alu_stop = 1'b1;
          m_st = 4;
        end
        m_n++;
      end else if (m_st == 4) begin
        bus.alu_outbus = m_res[63:0];
        m_st = 5;
      end else if (m_st == 5) begin
        bus.alu_outbus = m_res[127:64];
        m_st = 0;
      end
    end
  end
  task automatic wait_ready(input logic [1:0] exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.req_ready == 2'b00 && n < 50);
    check("req_ready", bus.req_ready, exp);
  endtask
  task automatic issue(input int id, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    bus.req_op[2*id +: 2] = op;
    bus.req_a[64*id +: 64] = a;
    bus.req_b[64*id +: 64] = b;
    bus.req_valid[id] = 1'b1;
    wait_ready(id == 1 ? 2'b10 : 2'b01);
    bus.req_valid[id] = 1'b0;
  endtask
  task automatic wait_rsp(output int n);
    n = 0;
    while (bus.rsp_valid == 2'b00 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic get_rsp(input int id, input logic [63:0] lo, input logic [63:0] hi, input logic err, output int n);
    wait_rsp(n);
    check("rsp_valid", bus.rsp_valid, id == 1 ? 2'b10 : 2'b01);
    check("rsp_lo", bus.rsp_lo, lo);
    check("rsp_hi", bus.rsp_hi, hi);
    check("rsp_err", bus.rsp_err, err);
    bus.rsp_ready[id] = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    check("rsp_drop", bus.rsp_valid, 2'b00);
  endtask
  initial begin
    int n;
    int b0;
    bus.req_valid = '0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = '0;
    repeat (2) @(negedge clk);
    check("rst_ctl", {bus.req_ready, bus.rsp_valid, bus.alu_bgn, bus.alu_opcode, bus.rsp_err}, 0);
    check("rst_data", {bus.alu_inbus, bus.rsp_lo}, 0);
    rst_b = 1'b1;
    @(negedge clk);
    issue(0, 2'd0, 64'd5, 64'd7);
    check("bgn_start", bus.alu_bgn, 1'b1);
    check("opc_add", bus.alu_opcode, 2'd0);
    get_rsp(0, 64'd12, 64'd0, 1'b0, n);
    check("inbus_a", m_a, 64'd5);
    check("inbus_b", m_b, 64'd7);
    check("bgn_once", m_bgn, 1);
    issue(1, 2'd1, 64'd3, 64'd5);
    get_rsp(1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0, n);
    issue(0, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    get_rsp(0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0, n);
    issue(1, 2'd3, 64'd100, 64'd7);
    get_rsp(1, 64'd14, 64'd2, 1'b0, n);
    b0 = m_bgn;
    issue(1, 2'd3, 64'd9, 64'd0);
    check("dz_no_bgn", bus.alu_bgn, 1'b0);
    get_rsp(1, 64'd0, 64'd0, 1'b1, n);
    check("dz_bgn_cnt", m_bgn, b0);
    bus.req_op = 4'b1010;
    bus.req_a = {64'h8000_0000_0000_0000, 64'd3};
    bus.req_b = {64'd4, 64'd4};
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ready(k % 2 == 1 ? 2'b10 : 2'b01);
      if (k == 3) bus.req_valid = 2'b00;
      get_rsp(k % 2, k % 2 == 1 ? 64'd0 : 64'd12, k % 2 == 1 ? 64'd2 : 64'd0, 1'b0, n);
    end
    issue(0, 2'd0, 64'd1, 64'd1);
    bus.req_op[3:2] = 2'd0;
    bus.req_a[127:64] = 64'd1;
    bus.req_b[127:64] = 64'd2;
    bus.req_valid[1] = 1'b1;
    wait_rsp(n);
    stop_inj = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", bus.rsp_valid, 2'b01);
      check("bp_lo", bus.rsp_lo, 64'd2);
      check("bp_no_grant", bus.req_ready, 2'b00);
      @(negedge clk);
    end
    stop_inj = 1'b0;
    bus.rsp_ready[0] = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    wait_ready(2'b10);
    bus.req_valid = 2'b00;
    get_rsp(1, 64'd3, 64'd0, 1'b0, n);
    hang = 1'b1;
    issue(0, 2'd0, 64'd8, 64'd9);
    get_rsp(0, 64'd0, 64'd0, 1'b1, n);
    check("timeout_cycles", n, 303);
    issue(0, 2'd2, 64'd3, 64'd4);
    repeat (6) @(negedge clk);
    check("wait_opc", bus.alu_opcode, 2'd2);
    #2 rst_b = 1'b0;
    #1;
    check("arst_ctl", {bus.req_ready, bus.rsp_valid, bus.alu_bgn, bus.alu_opcode, bus.rsp_err}, 0);
    check("arst_data", {bus.alu_inbus, bus.rsp_hi}, 0);
    @(negedge clk);
    rst_b = 1'b1;
    hang = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) n++;
    end
    check("no_rsp_after_rst", n, 0);
    bus.req_op = 4'b1010;
    bus.req_a = {64'h8000_0000_0000_0000, 64'd3};
    bus.req_b = {64'd4, 64'd4};
    bus.req_valid = 2'b11;
    wait_ready(2'b01);
    bus.req_valid[0] = 1'b0;
    get_rsp(0, 64'd12, 64'd0, 1'b0, n);
    wait_ready(2'b10);
    bus.req_valid = 2'b00;
    get_rsp(1, 64'd0, 64'd2, 1'b0, n);
    check("model_bad", m_bad, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 300, max cycles in WAIT before the operation is aborted with error.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_b  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-005 req_ready  output  2  per-requester accept strobe; one-cycle pulse.
REQ-006 req_op  input  4  opcode per requester, bits [2i+1:2i]: 00 add, 01 sub, 10 mul, 11 div.
REQ-007 req_a, req_b  input  128 each  operands per requester, bits [64i+63:64i].
REQ-008 rsp_valid  output  2  response valid to requester i.
REQ-009 rsp_ready  input  2  response accepted by requester i.
REQ-010 rsp_lo, rsp_hi  output  64 each  result words; rsp_err  output  1  error flag (shared, qualified by rsp_valid).
REQ-011 alu_bgn  output  1  start pulse to the arithmetic unit.
REQ-012 alu_opcode  output  2  opcode to the arithmetic unit.
REQ-013 alu_inbus  output  64  operand bus to the arithmetic unit.
REQ-014 alu_stop  input  1  done from the arithmetic unit; alu_outbus  input  64  result bus.

Function
REQ-015 FSM states SHALL be IDLE, START, LOAD_A, LOAD_B, WAIT, CAP_LO, CAP_HI, RESP; exactly one operation in flight.
REQ-016 IDLE: if any req_valid high, grant by round-robin (last-granted requester has lowest priority), pulse req_ready of winner, latch op/a/b and winner id, go START.
REQ-017 Grant with div opcode and req_b==0 SHALL skip the unit: rsp_lo=0, rsp_hi=0, rsp_err=1, go RESP directly.
REQ-018 START: alu_bgn=1 for exactly one cycle; alu_opcode=latched op, held constant from START through CAP_HI.
REQ-019 LOAD_A: alu_inbus=latched a; LOAD_B: alu_inbus=latched b; alu_inbus=0 in every other state.
REQ-020 WAIT: count cycles from 0; on alu_stop=1 go CAP_LO; if count reaches TIMEOUT with alu_stop low, set rsp_err=1, results 0, go RESP.
REQ-021 CAP_LO: capture alu_outbus into rsp_lo; if op is add/sub set rsp_hi=0, go RESP; else go CAP_HI.
REQ-022 CAP_HI: capture alu_outbus into rsp_hi, go RESP.
REQ-023 RESP: rsp_valid[id]=1, rsp_lo/rsp_hi/rsp_err stable until rsp_ready[id]=1; on handshake cycle clear rsp_valid, go IDLE.
REQ-024 No new grant while not in IDLE; req_valid deasserting after grant has no effect on latched operation.
REQ-025 Round-robin pointer SHALL update only on grant; simultaneous requests alternate 0,1,0,1...
REQ-026 alu_stop observed outside WAIT SHALL be ignored.
REQ-027 Add/sub results wrap modulo 2^64 as produced by the unit; the arbiter performs no arithmetic on results.
REQ-028 At most one bit of rsp_valid and req_ready high in any cycle.

Reset
REQ-029 On rst_b=0, immediately: state IDLE, all outputs 0, counter 0, round-robin pointer so requester 0 wins the first tie.
REQ-030 Reset mid-operation SHALL abandon it with no response; after release the arbiter accepts fresh requests only.

Verification
REQ-031 Single req0 add a=5, b=7; model returns 12 -> bgn pulse at START, inbus 5 then 7, rsp_valid[0], rsp_lo=12, rsp_hi=0, rsp_err=0.
REQ-032 req0 and req1 both valid mul every cycle -> grants alternate 0,1,0,1; each response on its own rsp_valid bit; hi/lo captured on consecutive cycles after stop.
REQ-033 req1 div b=0 -> req_ready[1] pulse, no alu_bgn, rsp_err=1, rsp_lo=rsp_hi=0.
REQ-034 Model never raises alu_stop, TIMEOUT=300 -> rsp_err=1 exactly 300 cycles after entering WAIT, then IDLE.
REQ-035 Hold rsp_ready low for 10 cycles -> rsp_valid and data stable all 10 cycles, no new grant despite pending req_valid.
REQ-036 Assert rst_b=0 during WAIT -> all outputs 0 asynchronously, no response after release, next tie granted to requester 0.
